io_panel: RTL and testbench

IO_PANEL -- requirements
Module: io_panel

---
 rtl/io_panel_pkg.sv | 37 +++
 rtl/io_debounce.sv | 49 ++++
 rtl/io_panel.sv | 145 ++++++++++++++
 tb/tb_io_panel.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_panel_pkg.sv
// Shared display command encodings and the hex-to-seven-segment decode.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}; dp is always off.
package io_panel_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_CLEAR = 2'b11
    } disp_cmd_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One-bit synchroniser + debouncer; a steady change reaches o_level 2+DEBOUNCE_CYC cycles later.
// o_rise strobes for one cycle together with the rising edge of o_level; no backpressure.
module io_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/io_panel.sv
// Board I/O panel: debounced switches/buttons, multiplexed 7-seg display, blinking LEDs.
// Display/LED outputs are registered one cycle after their inputs; no backpressure.
module io_panel
    import io_panel_pkg::*;
#(
    parameter int NUM_SW       = 4,
    parameter int NUM_BTN      = 4,
    parameter int NUM_DIGITS   = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SCAN_CYC     = 10,
    parameter int BLINK_CYC    = 5000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_SW-1:0]       Slide_Switch,
    input  logic [NUM_BTN-1:0]      Button,
    input  logic [1:0]              Disp_Cmd,
    input  logic [4*NUM_DIGITS-1:0] Disp_Data,
    input  logic [2:0]              Disp_Sel,
    input  logic [3:0]              LED_Pattern,
    input  logic                    LED_Blink,
    output logic [NUM_SW-1:0]       User_Switch,
    output logic [NUM_BTN-1:0]      Button_Level,
    output logic [NUM_BTN-1:0]      Button_Pulse,
    output logic [3:0]              LED,
    output logic [7:0]              Seg_Pattern,
    output logic [NUM_DIGITS-1:0]   Seg_Anode
);

    localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W  = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [SCAN_W-1:0] SCAN_MAX  = SCAN_W'(SCAN_CYC - 1);
    localparam logic [DIG_W-1:0]  DIG_MAX   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLINK_MAX = BLK_W'(BLINK_CYC - 1);

    logic [NUM_SW-1:0]       w_sw_rise_unused;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [SCAN_W-1:0]       r_scan_cnt;
    logic [DIG_W-1:0]        r_digit;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [7:0]              r_seg;
    logic [BLK_W-1:0]        r_blink_cnt;
    logic                    r_blink_off;
    logic [3:0]              r_led;
    logic [3:0]              w_nib;
    logic [NUM_DIGITS-1:0]   w_anode;
    disp_cmd_e               w_cmd;

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
        io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_raw   (Slide_Switch[gi]),
            .o_level (User_Switch[gi]),
            .o_rise  (w_sw_rise_unused[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_raw   (Button[gi]),
            .o_level (Button_Level[gi]),
            .o_rise  (Button_Pulse[gi])
        );
    end

    assign w_cmd = disp_cmd_e'(Disp_Cmd);

    // Out-of-range nibble writes match no digit and so leave the word untouched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_disp <= '0;
        end else begin
            case (w_cmd)
                CMD_LOAD:  r_disp <= Disp_Data;
                CMD_WRITE: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (Disp_Sel == 3'(i)) r_disp[i*4 +: 4] <= Disp_Data[3:0];
                    end
                end
                CMD_CLEAR: r_disp <= '0;
                default:   r_disp <= r_disp;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
        end else if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_digit    <= (r_digit == DIG_MAX) ? '0 : r_digit + DIG_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        w_nib   = '0;
        w_anode = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit == DIG_W'(i)) begin
                w_nib      = r_disp[i*4 +: 4];
                w_anode[i] = 1'b0;
            end
        end
    end

    // Anode and pattern share one register stage so they always switch on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_anode <= '1;
            r_seg   <= SEG_BLANK;
        end else begin
            r_anode <= w_anode;
            r_seg   <= hex_to_seg(w_nib);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
            r_led       <= 4'b0000;
        end else begin
            if (r_blink_cnt == BLINK_MAX) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
            r_led <= (LED_Blink && r_blink_off) ? 4'b0000 : LED_Pattern;
        end
    end

    assign Seg_Anode   = r_anode;
    assign Seg_Pattern = r_seg;
    assign LED         = r_led;

endmodule

// File: tb/tb_io_panel.sv
// Self-checking bench for io_panel: vector table for display commands, scoreboarded LEDs,
// and hand-written sequences for debounce, scan walk, reset and blink timing.
module tb_io_panel;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  Slide_Switch;
    logic [3:0]  Button;
    logic [1:0]  Disp_Cmd;
    logic [15:0] Disp_Data;
    logic [2:0]  Disp_Sel;
    logic [3:0]  LED_Pattern;
    logic        LED_Blink;
    logic [3:0]  User_Switch;
    logic [3:0]  Button_Level;
    logic [3:0]  Button_Pulse;
    logic [3:0]  LED;
    logic [7:0]  Seg_Pattern;
    logic [3:0]  Seg_Anode;

    int checks = 0;
    int errors = 0;

    logic [15:0] disp_q[$];
    logic [3:0]  led_q[$];

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] data;
        logic [2:0]  sel;
        logic [15:0] exp_word;
    } disp_vec_t;

    disp_vec_t vecs[12];

    io_panel #(
        .NUM_SW(4), .NUM_BTN(4), .NUM_DIGITS(4),
        .DEBOUNCE_CYC(16), .SCAN_CYC(10), .BLINK_CYC(5000)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Slide_Switch (Slide_Switch),
        .Button       (Button),
        .Disp_Cmd     (Disp_Cmd),
        .Disp_Data    (Disp_Data),
        .Disp_Sel     (Disp_Sel),
        .LED_Pattern  (LED_Pattern),
        .LED_Blink    (LED_Blink),
        .User_Switch  (User_Switch),
        .Button_Level (Button_Level),
        .Button_Pulse (Button_Pulse),
        .LED          (LED),
        .Seg_Pattern  (Seg_Pattern),
        .Seg_Anode    (Seg_Anode)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] seg_exp(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sw"},    32'(User_Switch),  32'h0);
        check({tag, "_lvl"},   32'(Button_Level), 32'h0);
        check({tag, "_pulse"}, 32'(Button_Pulse), 32'h0);
        check({tag, "_led"},   32'(LED),          32'h0);
        check({tag, "_anode"}, 32'(Seg_Anode),    32'hF);
        check({tag, "_seg"},   32'(Seg_Pattern),  32'hFF);
    endtask

    // Watches one full scan period and checks every driven digit against the word.
    task automatic check_display(input logic [15:0] word);
        int idx;
        for (int c = 0; c < 40; c++) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!Seg_Anode[i]) idx = i;
            check("disp_anode_onehot", 32'($countones(~Seg_Anode)), 32'd1);
            check("disp_seg", 32'(Seg_Pattern), 32'(seg_exp(word[idx*4 +: 4])));
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [15:0] word;
        logic [15:0] exp_word;
        logic [3:0]  pat;
        int          d;

        vecs[0]  = '{2'b11, 16'hFFFF, 3'd0, 16'h0000};
        vecs[1]  = '{2'b01, 16'h1A2F, 3'd0, 16'h1A2F};
        vecs[2]  = '{2'b00, 16'hFFFF, 3'd1, 16'h1A2F};
        vecs[3]  = '{2'b11, 16'h1234, 3'd0, 16'h0000};
        vecs[4]  = '{2'b10, 16'h0007, 3'd2, 16'h0700};
        vecs[5]  = '{2'b10, 16'h000B, 3'd5, 16'h0700};
        vecs[6]  = '{2'b10, 16'hFFF3, 3'd0, 16'h0703};
        vecs[7]  = '{2'b10, 16'h000E, 3'd3, 16'hE703};
        vecs[8]  = '{2'b01, 16'h89BC, 3'd0, 16'h89BC};
        vecs[9]  = '{2'b10, 16'h0005, 3'd4, 16'h89BC};
        vecs[10] = '{2'b01, 16'h4D56, 3'd0, 16'h4D56};
        vecs[11] = '{2'b10, 16'h0001, 3'd7, 16'h4D56};

        RST = 1'b1; Slide_Switch = '0; Button = '0; Disp_Cmd = 2'b00; Disp_Data = '0;
        Disp_Sel = '0; LED_Pattern = '0; LED_Blink = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Button press: level and one-cycle pulse exactly 18 cycles after the raw edge.
        Button[0] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge CLK);
            check("btn_press_lvl",   32'(Button_Level[0]), 32'(k >= 18));
            check("btn_press_pulse", 32'(Button_Pulse[0]), 32'(k == 18));
        end
        Button[0] = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge CLK);
            check("btn_release_lvl",   32'(Button_Level[0]), 32'(k < 18));
            check("btn_release_pulse", 32'(Button_Pulse), 32'h0);
        end

        // Glitches of 10 and 15 cycles must never be accepted.
        Slide_Switch[2] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            check("sw_glitch10", 32'(User_Switch), 32'h0);
            if (k == 10) Slide_Switch[2] = 1'b0;
        end
        Slide_Switch[2] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            check("sw_glitch15", 32'(User_Switch), 32'h0);
            if (k == 15) Slide_Switch[2] = 1'b0;
        end
        Slide_Switch = 4'b1010;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            check("sw_held", 32'(User_Switch), (k >= 18) ? 32'hA : 32'h0);
        end
        Slide_Switch = 4'b0000;
        repeat (20) @(negedge CLK);
        check("sw_cleared", 32'(User_Switch), 32'h0);

        // Steady LED: each driven pattern must appear one cycle later.
        LED_Pattern = 4'($urandom_range(0, 15));
        led_q.push_back(LED_Pattern);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check("led_steady", 32'(LED), 32'(led_q.pop_front()));
            LED_Pattern = 4'($urandom_range(0, 15));
            led_q.push_back(LED_Pattern);
        end
        @(negedge CLK);
        check("led_steady", 32'(LED), 32'(led_q.pop_front()));

        // Display command table.
        foreach (vecs[v]) begin
            Disp_Cmd = vecs[v].cmd; Disp_Data = vecs[v].data; Disp_Sel = vecs[v].sel;
            disp_q.push_back(vecs[v].exp_word);
            @(negedge CLK);
            Disp_Cmd = 2'b00; Disp_Data = 16'hDEAD; Disp_Sel = 3'd0;
            @(negedge CLK);
            exp_word = disp_q.pop_front();
            check_display(exp_word);
        end

        // Scan walk from reset: digit 0 first, 10 cycles per digit, wrap to digit 0.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; Disp_Cmd = 2'b01; Disp_Data = 16'h1A2F;
        word = 16'h1A2F;
        for (int k = 1; k <= 41; k++) begin
            @(negedge CLK);
            if (k == 1) Disp_Cmd = 2'b00;
            d = ((k - 1) / 10) % 4;
            check("walk_anode", 32'(Seg_Anode), 32'(~(4'b0001 << d) & 4'hF));
            check("walk_seg", 32'(Seg_Pattern),
                  (k == 1) ? 32'(seg_exp(4'h0)) : 32'(seg_exp(word[d*4 +: 4])));
        end

        // Reset with an accepted button, a pending button and switches set.
        Button[1] = 1'b1; Slide_Switch = 4'b1111; LED_Pattern = 4'b0110; LED_Blink = 1'b0;
        repeat (25) @(negedge CLK);
        check("pre_rst_lvl", 32'(Button_Level[1]), 32'h1);
        Button[2] = 1'b1;
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midrst");
        RST = 1'b0; Button = '0; Slide_Switch = '0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge CLK);
            if (k == 1) check("post_rst_digit0", 32'(Seg_Anode), 32'hE);
            check("post_rst_pulse", 32'(Button_Pulse), 32'h0);
            check("post_rst_lvl",   32'(Button_Level), 32'h0);
        end

        // Blink: 5000 on / 5000 off from reset; phase unaffected by a pattern change.
        RST = 1'b1; LED_Pattern = 4'b1010; LED_Blink = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= 15000; k++) begin
            @(negedge CLK);
            pat = (k <= 7000) ? 4'b1010 : 4'b0110;
            check("blink", 32'(LED), (((k - 1) / 5000) % 2 == 1) ? 32'h0 : 32'(pat));
            if (k == 7000) LED_Pattern = 4'b0110;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
